approx_mult_pipe: RTL

// - Parametrised, pipelined unsigned WxW approximate multiplier; successor to the fixed 8x8 combinational approximate multipliers.
// - Rows x[W-1:L] are multiplied exactly; rows x[L-1:0] pass through a configurable OR/AND pair-compression tree.
// - Adds a valid/ready stream interface, a 3-stage pipeline with backpressure, and a runtime exact/approximate select.

---
 rtl/approx_mult_pkg.sv | 23 ++
 rtl/approx_mult_lo_tree.sv | 73 +++++++
 rtl/approx_mult_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
// Shared definitions for the pipelined approximate multiplier:
//   STAGES        - pipeline depth (input -> out_valid latency)
//   stage_valid_t - one valid bit per pipeline stage
//   lo_width()    - width of the low-row partial sum y*x[L-1:0]
//   hi_width()    - width of the exact high-row product y*x[W-1:L]
package approx_mult_pkg;

  localparam int STAGES = 3;

  typedef logic [STAGES-1:0] stage_valid_t;

  // y*x[L-1:0] never exceeds W+L bits. Keep one bit when L=0 so no vector is zero-width.
  function automatic int lo_width(input int w, input int l);
    return (l == 0) ? 1 : w + l;
  endfunction

  // y*x[W-1:L] needs W+(W-L) bits. Keep one bit when L=W (there are no high rows).
  function automatic int hi_width(input int w, input int l);
    return (l < w) ? 2 * w - l : 1;
  endfunction

endpackage

// File: rtl/approx_mult_lo_tree.sv
// approx_mult_lo_tree
// Combinational compressor for the low rows x[L-1:0] of a WxW product.
// Ports:
//   x_lo      in  L (1 when L=0)  low operand rows
//   y         in  W               full second operand
//   approx_en in  1               1: approximate tree, 0: exact y*x_lo
//   lo        out lo_width(W,L)   low-row sum, column-aligned to bit 0
// Rows pair as (2k,2k+1). Per column, (a|b) is kept from C_MIN upward and
// (a&b) is added back from C_AND upward, which makes those columns exact.
// Columns below C_MIN are dropped. An unpaired last row keeps its bits at
// columns >= C_MIN. Because every term is <= its exact counterpart, lo never
// exceeds y*x_lo.
module approx_mult_lo_tree
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int L     = 6,
  parameter int C_MIN = 9,
  parameter int C_AND = 11,
  localparam int LX   = (L > 0) ? L : 1,
  localparam int LW   = lo_width(W, L)
) (
  input  logic [LX-1:0] x_lo,
  input  logic [W-1:0]  y,
  input  logic          approx_en,
  output logic [LW-1:0] lo
);

  localparam int PW = 2 * W;
  localparam int NP = L / 2;

  // Column masks: MASK_MIN selects c >= C_MIN, MASK_AND selects the columns that also take a&b.
  localparam logic [PW-1:0] MASK_MIN = {PW{1'b1}} << C_MIN;
  localparam logic [PW-1:0] MASK_AND = ({PW{1'b1}} << C_AND) & MASK_MIN;

  generate
    if (L == 0) begin : g_none
      assign lo = '0;
    end else begin : g_tree
      logic [PW-1:0] row [L];
      logic [PW-1:0] acc [NP+1];
      logic [PW-1:0] odd_term;
      logic [PW-1:0] approx_lo;
      logic [PW-1:0] exact_lo;

      // Partial-product row i, already shifted to its column position.
      for (genvar gi = 0; gi < L; gi++) begin : g_row
        assign row[gi] = ({{W{1'b0}}, y} << gi) & {PW{x_lo[gi]}};
      end

      // Each pair contributes sum over c of (a|b)<<c, plus (a&b)<<c in the exact columns.
      assign acc[0] = '0;
      for (genvar gi = 0; gi < NP; gi++) begin : g_pair
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        assign a = row[2*gi];
        assign b = row[2*gi+1];
        assign acc[gi+1] = acc[gi] + ((a | b) & MASK_MIN) + ((a & b) & MASK_AND);
      end

      if (L % 2 == 1) begin : g_odd
        assign odd_term = row[L-1] & MASK_MIN;
      end else begin : g_even
        assign odd_term = '0;
      end

      assign approx_lo = acc[NP] + odd_term;
      assign exact_lo  = {{W{1'b0}}, y} * PW'(x_lo);
      assign lo        = LW'(approx_en ? approx_lo : exact_lo);
    end
  endgenerate

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
// Pipelined unsigned WxW approximate multiplier with valid/ready handshake.
// Stage 1 registers the operands, stage 2 the high-row product and low-row
// sum, stage 3 the final product. Latency 3, throughput 1 beat per cycle.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  input beat handshake
//   x, y        [W]      unsigned operands
//   approx_en            1: approximate low rows, 0: exact product
//   out_valid / out_ready output beat handshake
//   z           [2W]     product
// Optional macro APPROX_MULT_ERR_STATS_EN adds:
//   stats_clr   in  1    clears the statistics
//   err_cnt     out 32   output transfers with nonzero error (saturating)
//   err_max     out 2W   largest error seen on an output transfer
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int L     = 6,
  parameter int C_MIN = 9,
  parameter int C_AND = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           approx_en,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef APPROX_MULT_ERR_STATS_EN
  input  logic           stats_clr,
  output logic [31:0]    err_cnt,
  output logic [2*W-1:0] err_max,
`endif
  output logic [2*W-1:0] z
);

  localparam int PW = 2 * W;
  localparam int LW = lo_width(W, L);
  localparam int HW = hi_width(W, L);
  localparam int LX = (L > 0) ? L : 1;

  stage_valid_t  valid_reg;
  logic          en1, en2, en3;

  logic [W-1:0]  x1_reg, y1_reg;
  logic          ae1_reg;
  logic [HW-1:0] hi2_reg, hi_next;
  logic [LW-1:0] lo2_reg, lo_next;
  logic [PW-1:0] z_reg, z_next;

  // A stage may load when it is empty or when the stage after it is moving,
  // so bubbles collapse and a stalled output holds everything behind it.
  assign en3       = !valid_reg[2] || out_ready;
  assign en2       = !valid_reg[1] || en3;
  assign en1       = !valid_reg[0] || en2;
  assign in_ready  = en1;
  assign out_valid = valid_reg[2];
  assign z         = z_reg;

  generate
    if (L < W) begin : g_hi
      assign hi_next = HW'(y1_reg) * HW'(x1_reg[W-1:L]);
    end else begin : g_no_hi
      assign hi_next = '0;
    end
  endgenerate

  approx_mult_lo_tree #(
    .W     (W),
    .L     (L),
    .C_MIN (C_MIN),
    .C_AND (C_AND)
  ) u_lo_tree (
    .x_lo      (x1_reg[LX-1:0]),
    .y         (y1_reg),
    .approx_en (ae1_reg),
    .lo        (lo_next)
  );

  assign z_next = (PW'(hi2_reg) << L) + PW'(lo2_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      ae1_reg   <= 1'b0;
      hi2_reg   <= '0;
      lo2_reg   <= '0;
      z_reg     <= '0;
    end else begin
      if (en1) begin
        valid_reg[0] <= in_valid;
        if (in_valid) begin
          x1_reg  <= x;
          y1_reg  <= y;
          ae1_reg <= approx_en;
        end
      end
      if (en2) begin
        valid_reg[1] <= valid_reg[0];
        if (valid_reg[0]) begin
          hi2_reg <= hi_next;
          lo2_reg <= lo_next;
        end
      end
      if (en3) begin
        valid_reg[2] <= valid_reg[1];
        if (valid_reg[1]) begin
          z_reg <= z_next;
        end
      end
    end
  end

`ifdef APPROX_MULT_ERR_STATS_EN
  logic [PW-1:0] exact2_reg;
  logic [PW-1:0] err3_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exact2_reg <= '0;
      err3_reg   <= '0;
    end else begin
      if (en2 && valid_reg[0]) begin
        exact2_reg <= PW'(x1_reg) * PW'(y1_reg);
      end
      if (en3 && valid_reg[1]) begin
        err3_reg <= exact2_reg - z_next;
      end
    end
  end

  // Statistics only see beats that actually leave the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (stats_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (valid_reg[2] && out_ready && (err3_reg != '0)) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 32'd1;
      end
      if (err3_reg > err_max) begin
        err_max <= err3_reg;
      end
    end
  end
`endif

endmodule
